display_mode_arbiter: RTL and testbench

- Parametrised successor to the top-level menu/game output selection.
- Owns the system mode state machine: MENU, PLAY, PAUSE, OVER.
- Selects one of NUM_SRC source bundles (oled pixel, led, seg, an) and drives the board outputs through a registered mux.
- Adds pause/resume, a game-over hold period, a return to menu, a game restart pulse, and frame-aligned blanking on every mode change.

---
 rtl/display_mode_arbiter_pkg.sv | 26 ++
 rtl/display_mode_arbiter_rise_detect.sv | 23 ++
 rtl/display_mode_arbiter.sv | 175 +++++++++++++++++
 tb/tb_display_mode_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_mode_arbiter_pkg.sv
// Shared definitions for the display mode arbiter.
// Holds the system mode encoding and the blank-level values driven
// onto the board outputs while blanking or in reset.
package display_mode_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_MENU  = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_PAUSE = 2'd2,
    MODE_OVER  = 2'd3
  } mode_e;

  localparam logic [15:0] OLED_BLANK = 16'h0000;
  localparam logic [15:0] LED_OFF    = 16'h0000;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  // Request line positions inside the edge-detector bank.
  localparam int unsigned REQ_START = 0;
  localparam int unsigned REQ_PAUSE = 1;
  localparam int unsigned REQ_QUIT  = 2;
  localparam int unsigned REQ_OVER  = 3;
  localparam int unsigned REQ_ACK   = 4;
  localparam int unsigned REQ_NUM   = 5;

endpackage

// File: rtl/display_mode_arbiter_rise_detect.sv
// Bank of rising-edge detectors.
// Ports: clk_i, rst_i (async active-high), req_i[WIDTH] level inputs,
//        rise_c_o[WIDTH] combinational one-cycle pulse on each 0->1 edge.
module rise_detect #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] rise_c_o
);

  logic [WIDTH-1:0] req_q;

  // One-flop history per line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) req_q <= '0;
    else       req_q <= req_i;
  end

  assign rise_c_o = req_i & ~req_q;

endmodule

// File: rtl/display_mode_arbiter.sv
// Display mode arbiter: owns the MENU/PLAY/PAUSE/OVER state machine,
// blanks the board outputs for whole frames after each mode change, and
// drives the selected source bundle through a registered mux.
// Ports: clock_100mhz, reset (async active-high), frame_tick,
//        start/pause/quit/game_over/ack request levels,
//        packed oled/led/seg/an source buses, registered board outputs,
//        game status flags and the current mode.
module display_mode_arbiter
  import display_mode_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC          = 4,
  parameter int unsigned SRC_MENU         = 0,
  parameter int unsigned SRC_PLAY         = 1,
  parameter int unsigned SRC_PAUSE        = 2,
  parameter int unsigned SRC_OVER         = 3,
  parameter int unsigned BLANK_FRAMES     = 2,
  parameter int unsigned OVER_HOLD_FRAMES = 60,
  parameter int unsigned CNT_W            = 8
) (
  input  logic                  clock_100mhz,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  start_req,
  input  logic                  pause_req,
  input  logic                  quit_req,
  input  logic                  game_over_req,
  input  logic                  ack_req,
  input  logic [16*NUM_SRC-1:0] oled_in,
  input  logic [16*NUM_SRC-1:0] led_in,
  input  logic [8*NUM_SRC-1:0]  seg_in,
  input  logic [4*NUM_SRC-1:0]  an_in,
  output logic [15:0]           oled_data,
  output logic [15:0]           led,
  output logic [7:0]            seg,
  output logic [3:0]            an,
  output logic                  game_active,
  output logic                  game_paused,
  output logic                  game_restart,
  output logic [1:0]            mode
);

  localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  mode_e              state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic [15:0]        oled_q, oled_d;
  logic [15:0]        led_q, led_d;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               active_q, active_d;
  logic               paused_q, paused_d;
  logic               restart_q, restart_d;
  logic [REQ_NUM-1:0] req_c, rise_c;
  logic [SEL_W-1:0]   sel_c;
  logic               hold_done_c;
  logic               blanking_c;

  assign req_c = {ack_req, game_over_req, quit_req, pause_req, start_req};

  rise_detect #(.WIDTH(REQ_NUM)) u_rise (
    .clk_i    (clock_100mhz),
    .rst_i    (reset),
    .req_i    (req_c),
    .rise_c_o (rise_c)
  );

  assign hold_done_c = (hold_cnt_q >= CNT_W'(OVER_HOLD_FRAMES));
  assign blanking_c  = (blank_cnt_q != '0);

  // Next-state, counters and output mux.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    blank_cnt_d = blank_cnt_q;
    sel_c       = SEL_W'(SRC_MENU);

    unique case (state_q)
      MODE_MENU: begin
        if (rise_c[REQ_START]) state_d = MODE_PLAY;
      end
      MODE_PLAY: begin
        if (rise_c[REQ_OVER])       state_d = MODE_OVER;
        else if (rise_c[REQ_QUIT])  state_d = MODE_MENU;
        else if (rise_c[REQ_PAUSE]) state_d = MODE_PAUSE;
      end
      MODE_PAUSE: begin
        if (rise_c[REQ_QUIT])       state_d = MODE_MENU;
        else if (rise_c[REQ_PAUSE]) state_d = MODE_PLAY;
      end
      MODE_OVER: begin
        // Early acks are simply dropped; only an ack after the hold counts.
        if (rise_c[REQ_QUIT])                    state_d = MODE_MENU;
        else if (rise_c[REQ_ACK] && hold_done_c) state_d = MODE_MENU;
      end
      default: state_d = MODE_MENU;
    endcase

    // Hold counter: cleared on entry to OVER, saturating frame count inside.
    if (state_q != MODE_OVER && state_d == MODE_OVER) begin
      hold_cnt_d = '0;
    end else if (state_q == MODE_OVER && frame_tick && !hold_done_c) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end

    // Any mode change (re)arms blanking; otherwise count frames down.
    if (state_d != state_q) begin
      blank_cnt_d = CNT_W'(BLANK_FRAMES);
    end else if (blanking_c && frame_tick) begin
      blank_cnt_d = blank_cnt_q - CNT_W'(1);
    end

    // Source follows the current state, so it lags a mode change by a cycle.
    unique case (state_q)
      MODE_MENU:  sel_c = SEL_W'(SRC_MENU);
      MODE_PLAY:  sel_c = SEL_W'(SRC_PLAY);
      MODE_PAUSE: sel_c = SEL_W'(SRC_PAUSE);
      MODE_OVER:  sel_c = SEL_W'(SRC_OVER);
      default:    sel_c = SEL_W'(SRC_MENU);
    endcase

    if (blanking_c) begin
      oled_d = OLED_BLANK;
      led_d  = LED_OFF;
      seg_d  = SEG_OFF;
      an_d   = AN_OFF;
    end else begin
      oled_d = oled_in[16*sel_c +: 16];
      led_d  = led_in[16*sel_c +: 16];
      seg_d  = seg_in[8*sel_c +: 8];
      an_d   = an_in[4*sel_c +: 4];
    end

    // Status flags decode the next state so they line up with mode.
    active_d  = (state_d == MODE_PLAY) || (state_d == MODE_PAUSE);
    paused_d  = (state_d == MODE_PAUSE);
    restart_d = (state_q == MODE_MENU) && (state_d == MODE_PLAY);
  end

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state_q     <= MODE_MENU;
      hold_cnt_q  <= '0;
      blank_cnt_q <= '0;
      oled_q      <= OLED_BLANK;
      led_q       <= LED_OFF;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      active_q    <= 1'b0;
      paused_q    <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      oled_q      <= oled_d;
      led_q       <= led_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      active_q    <= active_d;
      paused_q    <= paused_d;
      restart_q   <= restart_d;
    end
  end

  assign oled_data    = oled_q;
  assign led          = led_q;
  assign seg          = seg_q;
  assign an           = an_q;
  assign game_active  = active_q;
  assign game_paused  = paused_q;
  assign game_restart = restart_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_display_mode_arbiter.sv
module tb_display_mode_arbiter;

  localparam int unsigned NUM_SRC = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  frame_tick;
  logic                  start_req, pause_req, quit_req, game_over_req, ack_req;
  logic [16*NUM_SRC-1:0] oled_in, led_in;
  logic [8*NUM_SRC-1:0]  seg_in;
  logic [4*NUM_SRC-1:0]  an_in;
  logic [15:0]           oled_data, led;
  logic [7:0]            seg;
  logic [3:0]            an;
  logic                  game_active, game_paused, game_restart;
  logic [1:0]            mode;

  int checks = 0;
  int errors = 0;

  // Expected values are pushed as stimulus is driven, popped when sampled.
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  logic [15:0] src_oled [NUM_SRC];
  logic [15:0] src_led  [NUM_SRC];
  logic [7:0]  src_seg  [NUM_SRC];
  logic [3:0]  src_an   [NUM_SRC];

  display_mode_arbiter #(
    .NUM_SRC(4), .SRC_MENU(0), .SRC_PLAY(1), .SRC_PAUSE(2), .SRC_OVER(3),
    .BLANK_FRAMES(2), .OVER_HOLD_FRAMES(60), .CNT_W(8)
  ) dut (
    .clock_100mhz (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start_req    (start_req),
    .pause_req    (pause_req),
    .quit_req     (quit_req),
    .game_over_req(game_over_req),
    .ack_req      (ack_req),
    .oled_in      (oled_in),
    .led_in       (led_in),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .oled_data    (oled_data),
    .led          (led),
    .seg          (seg),
    .an           (an),
    .game_active  (game_active),
    .game_paused  (game_paused),
    .game_restart (game_restart),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_req = i[0]; pause_req = ~i[0]; quit_req = i[1];
      game_over_req = i[0]; ack_req = i[1]; frame_tick = i[0];
      step();
    end
    exp_q.push_back(16'd0); exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h000F); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL reset_mode got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (seg !== exp[7:0]) begin errors++; $display("FAIL reset_seg got %h want %h", seg, exp[7:0]); end
    exp = exp_q.pop_front(); checks++;
    if (an !== exp[3:0]) begin errors++; $display("FAIL reset_an got %h want %h", an, exp[3:0]); end
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL reset_led got %h want %h", led, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({game_active, game_paused, game_restart} !== exp[2:0])
      begin errors++; $display("FAIL reset_status got %b want %b", {game_active, game_paused, game_restart}, exp[2:0]); end
    start_req = 0; pause_req = 0; quit_req = 0; game_over_req = 0; ack_req = 0; frame_tick = 0;
    step();
    reset = 1'b0;
    step(); step();
    exp_q.push_back(src_led[0]);
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL menu_src_led got %h want %h", led, exp); end
  endtask

  task automatic test_start_blank();
    start_req = 1'b1;
    exp_q.push_back(16'd1); exp_q.push_back(16'd1);
    step();
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL start_mode got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (game_restart !== exp[0]) begin errors++; $display("FAIL restart_pulse got %b want %b", game_restart, exp[0]); end
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    step();
    exp = exp_q.pop_front(); checks++;
    if (game_restart !== exp[0]) begin errors++; $display("FAIL restart_width got %b want %b", game_restart, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL blank_led0 got %h want %h", led, exp); end
    pulse_tick();
    exp_q.push_back(16'd0);
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL blank_led1 got %h want %h", led, exp); end
    exp_q.push_back(16'd0); exp_q.push_back(16'hA5A5); exp_q.push_back({8'd0, src_seg[1]});
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL blank_led2 got %h want %h", led, exp); end
    step();
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL play_led got %h want %h", led, exp); end
    exp = exp_q.pop_front(); checks++;
    if (seg !== exp[7:0]) begin errors++; $display("FAIL play_seg got %h want %h", seg, exp[7:0]); end
  endtask

  task automatic test_pause_held();
    int         trans = 0;
    logic [1:0] prev;
    start_req = 1'b0;
    pause_req = 1'b1;
    prev = mode;
    exp_q.push_back(16'd1); exp_q.push_back(16'd2); exp_q.push_back(16'd1);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (mode !== prev) trans++;
      prev = mode;
    end
    exp = exp_q.pop_front(); checks++;
    if (trans !== int'(exp)) begin errors++; $display("FAIL pause_once got %0d want %0d", trans, exp); end
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL pause_mode got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (game_paused !== exp[0]) begin errors++; $display("FAIL pause_flag got %b want %b", game_paused, exp[0]); end
    pause_req = 1'b0;
    step();
    pause_req = 1'b1;
    exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    step();
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL resume_mode got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (game_paused !== exp[0]) begin errors++; $display("FAIL resume_flag got %b want %b", game_paused, exp[0]); end
  endtask

  task automatic test_over_hold();
    game_over_req = 1'b1;
    quit_req = 1'b1;
    exp_q.push_back(16'd3); exp_q.push_back(16'd0);
    step();
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL over_priority got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (game_active !== exp[0]) begin errors++; $display("FAIL over_active got %b want %b", game_active, exp[0]); end
    game_over_req = 0; quit_req = 0; pause_req = 0;
    step();
    for (int i = 0; i < 10; i++) pulse_tick();
    ack_req = 1'b1;
    exp_q.push_back(16'd3);
    step();
    ack_req = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL ack_early got %0d want %0d", mode, exp[1:0]); end
    step();
    for (int i = 0; i < 49; i++) pulse_tick();
    ack_req = 1'b1;
    exp_q.push_back(16'd3);
    step();
    ack_req = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL ack_59 got %0d want %0d", mode, exp[1:0]); end
    step();
    pulse_tick();
    ack_req = 1'b1;
    exp_q.push_back(16'd0);
    step();
    ack_req = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL ack_60 got %0d want %0d", mode, exp[1:0]); end
    step();
  endtask

  task automatic test_pause_ignores_over();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    pause_req = 1'b1;
    exp_q.push_back(16'd2); exp_q.push_back(16'd2);
    step();
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL enter_pause got %0d want %0d", mode, exp[1:0]); end
    game_over_req = 1'b1;
    step();
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL pause_over_ignored got %0d want %0d", mode, exp[1:0]); end
    quit_req = 1'b1;
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    step();
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL pause_quit got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (game_active !== exp[0]) begin errors++; $display("FAIL quit_active got %b want %b", game_active, exp[0]); end
    quit_req = 0; game_over_req = 0; pause_req = 0;
    step();
  endtask

  task automatic test_reset_mid_blank();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    pulse_tick();
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'h00FF);
    exp = exp_q.pop_front(); checks++;
    if (mode !== exp[1:0]) begin errors++; $display("FAIL async_mode got %0d want %0d", mode, exp[1:0]); end
    exp = exp_q.pop_front(); checks++;
    if (game_active !== exp[0]) begin errors++; $display("FAIL async_active got %b want %b", game_active, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (seg !== exp[7:0]) begin errors++; $display("FAIL async_seg got %h want %h", seg, exp[7:0]); end
    step();
    reset = 1'b0;
    exp_q.push_back(src_led[0]); exp_q.push_back(src_oled[0]);
    exp_q.push_back({8'd0, src_seg[0]}); exp_q.push_back({12'd0, src_an[0]});
    step();
    exp = exp_q.pop_front(); checks++;
    if (led !== exp) begin errors++; $display("FAIL post_rst_led got %h want %h", led, exp); end
    exp = exp_q.pop_front(); checks++;
    if (oled_data !== exp) begin errors++; $display("FAIL post_rst_oled got %h want %h", oled_data, exp); end
    exp = exp_q.pop_front(); checks++;
    if (seg !== exp[7:0]) begin errors++; $display("FAIL post_rst_seg got %h want %h", seg, exp[7:0]); end
    exp = exp_q.pop_front(); checks++;
    if (an !== exp[3:0]) begin errors++; $display("FAIL post_rst_an got %h want %h", an, exp[3:0]); end
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_oled[i] = 16'h1234 + 16'(i * 16'h1111);
      src_led[i]  = (i == 1) ? 16'hA5A5 : 16'h0F00 + 16'(i);
      src_seg[i]  = 8'hC0 | 8'(i);
      src_an[i]   = 4'(4'h1 << i) ^ 4'hA;
      oled_in[16*i +: 16] = src_oled[i];
      led_in[16*i +: 16]  = src_led[i];
      seg_in[8*i +: 8]    = src_seg[i];
      an_in[4*i +: 4]     = src_an[i];
    end
    test_reset();
    test_start_blank();
    test_pause_held();
    test_over_hold();
    test_pause_ignores_over();
    test_reset_mid_blank();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
